// File: rtl/word_serializer_pkg.sv
// word_serializer_pkg: shared serializer state type and counter width helper
package word_serializer_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: WIDTH-bit valid/ready word in, 1-bit valid/ready stream out, zero-bubble chaining
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    output logic             word_ready,
    output logic             bit_valid,
    output logic             bit_data,
    output logic             bit_last,
    input  logic             bit_ready
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] sreg, shifted;
    logic [CW-1:0] cnt;
    logic last, word_go, bit_go;
    always_comb begin
        last       = cnt == '0;
        bit_valid  = rst && state == SHIFT;
        bit_last   = bit_valid && last;
        bit_data   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        // bit_ready feeds word_ready directly so the next word loads on the final bit beat
        word_ready = rst && (state == IDLE || (state == SHIFT && last && bit_ready));
        word_go    = word_valid && word_ready;
        bit_go     = bit_valid && bit_ready;
        shifted    = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        state_n    = word_go ? SHIFT : (bit_go && last) ? IDLE : state;
    end
    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (word_go) begin
            cnt  <= CW'(WIDTH - 1);
            sreg <= word_data;
        end else if (bit_go && !last) begin
            cnt  <= cnt - CW'(1);
            sreg <= shifted;
        end
    end
endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parallel-in, serial-out stage sitting directly upstream of the 1-bit valid/ready pipeline stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted beat over a 1-bit valid/ready handshake.
- Its bit-side outputs connect straight to the pipeline stage's valid_in/data_in/ready_in.
- Supports zero-bubble back-to-back words, so a full-rate consumer sees one bit per cycle continuously.

Parameters:
- WIDTH, 8, bits per input word; legal range 2..64.
- MSB_FIRST, 0, 0 = bit 0 of the word is sent first; 1 = bit WIDTH-1 is sent first.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-low reset; sampled on the clk rising edge.
- word_valid, input, 1, producer asserts when word_data is valid.
- word_data, input, WIDTH, parallel word.
- word_ready, output, 1, block accepts word_data this cycle.
- bit_valid, output, 1, bit_data is valid.
- bit_data, output, 1, current serial bit.
- bit_last, output, 1, high with bit_valid on the final bit of a word.
- bit_ready, input, 1, downstream accepts bit_data this cycle.

Behaviour:
- Handshake rule: a transfer occurs on a cycle where valid && ready at the rising edge. Once bit_valid is asserted, bit_valid, bit_data and bit_last hold stable until the bit transfer completes.
- State: state enum {IDLE, SHIFT}; shift register sreg[WIDTH]; down-counter cnt of width $clog2(WIDTH).
- Reset (rst==0 at an edge): state=IDLE, cnt=0, sreg=0.
  - bit_valid=0, bit_last=0 and word_ready=0 (forced low) while rst is low.
  - Reset mid-word discards the partial word; no further bits of it are emitted.
- IDLE:
  - word_ready=1, bit_valid=0.
  - On word transfer: sreg<=word_data, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - bit_valid=1.
  - bit_data = sreg[0] when MSB_FIRST==0, else sreg[WIDTH-1].
  - bit_last = (cnt==0).
  - On bit transfer with cnt!=0: sreg shifts toward the output end (zero fill) and cnt<=cnt-1.
  - On bit transfer with cnt==0: the word is done. If a word transfer occurs the same cycle, load as in IDLE and remain in SHIFT; otherwise state<=IDLE.
- word_ready equation: (state==IDLE) || (state==SHIFT && cnt==0 && bit_ready). This is a combinational path from bit_ready to word_ready, and is intentional for zero-bubble chaining.
- Latency: first bit is visible 1 cycle after word acceptance. Sustained throughput is WIDTH bit beats per word with no idle cycle when word_valid and bit_ready are held high.
- Backpressure: bit_ready low stalls shifting indefinitely with no loss. word_valid during SHIFT with cnt!=0 is not accepted (word_ready=0).
- Invariant: bit_valid==(state==SHIFT).
- Counter never wraps: cnt reloads only on word acceptance.

Decomposition:
- Shared package: serializer state enum typedef {IDLE, SHIFT} and a localparam helper for counter width ($clog2(WIDTH), minimum 1).
- No sub-module: shift register, counter and FSM are small and in-line.
- Integration instantiates this block feeding the existing 1-bit pipeline stage; that pairing is exercised at the subsystem bench, not inside this module.

Test Plan:
- Single word, MSB_FIRST=0, WIDTH=8, word_data=0xA5, bit_ready=1:
  - bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after acceptance.
  - bit_last only on the 8th bit; then bit_valid=0 and word_ready=1.
- MSB_FIRST=1, word 0xA5 -> bits 1,0,1,0,0,1,0,1 (palindrome), then word 0x80 -> bits 1,0,0,0,0,0,0,0.
- Back-to-back words 0x3C then 0xC3, word_valid and bit_ready held high:
  - 16 consecutive bit beats with no gap.
  - word_ready pulses on the acceptance cycle and on the 8th-bit cycle.
  - bit_last on beats 8 and 16.
- Backpressure: word 0xF0, bit_ready low on beats 3-5:
  - bit_data/bit_valid/bit_last are stable across the stall.
  - The full sequence 0,0,0,0,1,1,1,1 is still delivered.
  - word_valid=1 with 0xFF during the stall is not accepted.
- Reset mid-word: rst low after 3 bits of 0xA5 -> next cycle bit_valid=0 and word_ready=0 while rst is low. After release, word_ready=1, and a new word 0x01 emits 1,0,0,0,0,0,0,0.
